// File: rtl/pot_smoother.sv
`default_nettype none
// ============================================================================
//  Module   : pot_smoother
//  Purpose  : Box-car average of the sampled pot reading with a hysteresis
//             dead-band and end-stop snap; publishes a stable 7-bit level.
//  Revision : 1.0
// ============================================================================
module pot_smoother #(
   parameter int SAMPLE_DIV = 1000,
   parameter int AVG_LOG2   = 4,
   parameter int HYST       = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] pot_in,
   output logic [6:0] pot_level,
   output logic       level_valid,
   output logic       level_changed,
   output logic [6:0] avg_raw
);

   localparam int c_DIV_W = $clog2(SAMPLE_DIV);
   localparam int c_ACC_W = 7 + AVG_LOG2;
   localparam int c_CNT_W = AVG_LOG2 + 1;
   localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(SAMPLE_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [7:0]         c_HYST    = 8'(HYST);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACCUM  = 2'd1;
   localparam logic [1:0] c_UPDATE = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [c_DIV_W-1:0] r_div;
   logic [c_ACC_W-1:0] r_acc;
   logic [c_CNT_W-1:0] r_count;
   logic [6:0]         r_pot_level;
   logic               r_level_valid;
   logic               r_level_changed;
   logic [6:0]         r_avg_raw;

   logic               w_tick;
   logic               w_div_run;
   logic               w_sample;
   logic               w_update;
   logic               w_flush;
   logic               w_publish;
   logic [6:0]         w_avg;
   logic [7:0]         w_diff;

   assign w_tick = (r_div == c_DIV_MAX);
   assign w_avg  = r_acc[c_ACC_W-1:AVG_LOG2];

   // Magnitude of avg - level, widened so the subtraction cannot wrap.
   always_comb begin
      w_diff = 8'd0;
      if (w_avg >= r_pot_level) begin
         w_diff = {1'b0, w_avg} - {1'b0, r_pot_level};
      end else begin
         w_diff = {1'b0, r_pot_level} - {1'b0, w_avg};
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      if (!enable) begin
         w_state_next = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE:   w_state_next = c_ACCUM;
            c_ACCUM:  if (w_tick && (r_count == c_LAST)) w_state_next = c_UPDATE;
            c_UPDATE: w_state_next = c_ACCUM;
            default:  w_state_next = c_IDLE;
         endcase
      end
   end

   // Output/control decode
   always_comb begin
      w_div_run = 1'b0;
      w_sample  = 1'b0;
      w_update  = 1'b0;
      w_flush   = 1'b1;
      if (enable) begin
         case (r_state)
            c_ACCUM: begin
               w_div_run = 1'b1;
               w_sample  = w_tick;
               w_flush   = 1'b0;
            end
            c_UPDATE: begin
               w_div_run = 1'b1;
               w_update  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // End-stop snap lets 0 and 127 be reached even inside the dead-band.
   assign w_publish = w_update &&
                      (!r_level_valid || (w_diff > c_HYST) ||
                       (((w_avg == 7'd0) || (w_avg == 7'd127)) && (w_avg != r_pot_level)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div           <= '0;
         r_acc           <= '0;
         r_count         <= '0;
         r_pot_level     <= 7'd0;
         r_level_valid   <= 1'b0;
         r_level_changed <= 1'b0;
         r_avg_raw       <= 7'd0;
      end else begin
         if (!w_div_run || w_tick) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + 1'b1;
         end

         if (w_flush) begin
            r_acc   <= '0;
            r_count <= '0;
         end else if (w_sample) begin
            r_acc   <= r_acc + {{AVG_LOG2{1'b0}}, pot_in};
            r_count <= r_count + 1'b1;
         end

         r_level_changed <= w_publish;
         if (w_update) begin
            r_avg_raw <= w_avg;
         end
         if (w_publish) begin
            r_pot_level   <= w_avg;
            r_level_valid <= 1'b1;
         end
      end
   end

   assign pot_level     = r_pot_level;
   assign level_valid   = r_level_valid;
   assign level_changed = r_level_changed;
   assign avg_raw       = r_avg_raw;

endmodule
`default_nettype wire

// File: tb/tb_pot_smoother.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pot_smoother
//  Purpose  : Self-checking bench for pot_smoother against a sample-queue model.
//  Revision : 1.0
// ============================================================================
module tb_pot_smoother;

   localparam int SAMPLE_DIV = 4;
   localparam int AVG_LOG2   = 2;
   localparam int HYST       = 2;
   localparam int N          = 1 << AVG_LOG2;
   // IDLE exit edge, N ticks spaced SAMPLE_DIV apart, then the UPDATE edge.
   localparam int FIRST_PUB  = 1 + N * SAMPLE_DIV + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [6:0] pot_in = 7'd0;
   logic [6:0] pot_level;
   logic       level_valid;
   logic       level_changed;
   logic [6:0] avg_raw;

   int n_checks = 0;
   int n_pass   = 0;

   int m_level, m_valid, m_changed, m_avg, m_run;
   int q[$];
   bit m_pending, m_published, m_ticked;

   pot_smoother #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .AVG_LOG2   (AVG_LOG2),
      .HYST       (HYST)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .pot_in        (pot_in),
      .pot_level     (pot_level),
      .level_valid   (level_valid),
      .level_changed (level_changed),
      .avg_raw       (avg_raw)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_level = 0; m_valid = 0; m_changed = 0; m_avg = 0;
      m_run = -1; q.delete();
      m_pending = 0; m_published = 0; m_ticked = 0;
   endtask

   // Model: the run starts with one idle edge, ticks every SAMPLE_DIV edges,
   // and a full sample set is published on the edge after its last tick.
   task automatic model_step();
      int sum, avg, d;
      m_published = 0;
      m_ticked    = 0;
      if (reset) begin
         model_reset();
         return;
      end
      m_changed = 0;
      if (!enable) begin
         m_run = -1; q.delete(); m_pending = 0;
         return;
      end
      if (m_pending) begin
         sum = 0;
         foreach (q[i]) sum += q[i];
         avg = sum / N;
         d = avg - m_level;
         if (d < 0) d = -d;
         m_avg = avg;
         if (m_valid == 0 || d > HYST || ((avg == 0 || avg == 127) && avg != m_level)) begin
            m_level = avg; m_valid = 1; m_changed = 1;
         end
         q.delete();
         m_pending   = 0;
         m_published = 1;
      end
      if (m_run < 0) m_run = 0;
      else m_run++;
      if (m_run > 0 && (m_run % SAMPLE_DIV) == 0) begin
         q.push_back(int'(pot_in));
         m_ticked = 1;
         if (q.size() == N) m_pending = 1;
      end
   endtask

   task automatic compare_outputs(input string ctx);
      check_eq({ctx, " pot_level"}, int'(pot_level), m_level);
      check_eq({ctx, " level_valid"}, int'(level_valid), m_valid);
      check_eq({ctx, " level_changed"}, int'(level_changed), m_changed);
      check_eq({ctx, " avg_raw"}, int'(avg_raw), m_avg);
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs("cycle");
   endtask

   task automatic run_window(output int cyc);
      cyc = 0;
      do begin
         tick_cycle();
         cyc++;
      end while (!m_published && cyc < 64);
      if (!m_published) check_eq("window timeout", 0, 1);
   endtask

   task automatic run_sample(input int v);
      int n;
      pot_in = 7'(v);
      n = 0;
      do begin
         tick_cycle();
         n++;
      end while (!m_ticked && n < 16);
      if (!m_ticked) check_eq("sample timeout", 0, 1);
   endtask

   task automatic window_of(input int v, output int cyc);
      pot_in = 7'(v);
      run_window(cyc);
   endtask

   initial begin
      int cyc, base, v;
      model_reset();
      #1;
      check_eq("reset pot_level", int'(pot_level), 0);
      check_eq("reset level_valid", int'(level_valid), 0);
      check_eq("reset level_changed", int'(level_changed), 0);
      check_eq("reset avg_raw", int'(avg_raw), 0);
      repeat (3) tick_cycle();

      // First publish after reset release
      reset = 1'b0; enable = 1'b1;
      window_of(64, cyc);
      check_eq("first latency", cyc, FIRST_PUB);
      check_eq("first level", int'(pot_level), 64);
      check_eq("first valid", int'(level_valid), 1);
      check_eq("first pulse", int'(level_changed), 1);
      check_eq("first avg", int'(avg_raw), 64);
      tick_cycle();
      check_eq("pulse width", int'(level_changed), 0);

      // Inside the dead-band, then outside it
      window_of(65, cyc);
      check_eq("hyst avg", int'(avg_raw), 65);
      check_eq("hyst hold", int'(pot_level), 64);
      check_eq("hyst no pulse", int'(level_changed), 0);
      window_of(67, cyc);
      check_eq("hyst move", int'(pot_level), 67);
      check_eq("hyst move pulse", int'(level_changed), 1);

      // Truncating average: 43/4 -> 10
      run_sample(10); run_sample(11); run_sample(11); run_sample(11);
      tick_cycle();
      check_eq("trunc avg", int'(avg_raw), 10);
      check_eq("trunc level", int'(pot_level), 10);

      // End-stop snaps
      window_of(126, cyc);
      check_eq("top pre", int'(pot_level), 126);
      window_of(127, cyc);
      check_eq("top snap", int'(pot_level), 127);
      check_eq("top snap pulse", int'(level_changed), 1);
      window_of(1, cyc);
      check_eq("bottom pre", int'(pot_level), 1);
      window_of(0, cyc);
      check_eq("bottom snap", int'(pot_level), 0);
      check_eq("bottom snap pulse", int'(level_changed), 1);

      // Reset part-way through a window
      run_sample(100); run_sample(100);
      reset = 1'b1;
      model_reset();
      #1;
      compare_outputs("async reset");
      check_eq("async reset valid", int'(level_valid), 0);
      repeat (2) tick_cycle();
      reset = 1'b0;
      window_of(100, cyc);
      check_eq("post-reset latency", cyc, FIRST_PUB);
      check_eq("post-reset level", int'(pot_level), 100);
      check_eq("post-reset pulse", int'(level_changed), 1);

      // Enable dropped mid-window
      window_of(50, cyc);
      check_eq("pre-disable level", int'(pot_level), 50);
      run_sample(70); run_sample(70);
      enable = 1'b0;
      repeat (5) tick_cycle();
      check_eq("disable hold", int'(pot_level), 50);
      check_eq("disable no pulse", int'(level_changed), 0);
      enable = 1'b1;
      window_of(90, cyc);
      check_eq("re-enable latency", cyc, FIRST_PUB);
      check_eq("re-enable level", int'(pot_level), 90);

      // Randomized noise around wandering set points, with enable blips
      base = 64;
      for (int i = 0; i < 1500; i++) begin
         if (i % 40 == 0) begin
            case ($urandom_range(0, 3))
               0:       base = 0;
               1:       base = 127;
               default: base = int'($urandom_range(0, 127));
            endcase
         end
         v = base + int'($urandom_range(0, 6)) - 3;
         if (v < 0) v = 0;
         if (v > 127) v = 127;
         pot_in = 7'(v);
         enable = ($urandom_range(0, 149) != 0);
         tick_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
